// File: rtl/instruction_sequencer_if.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_if
//   Bundles the instruction-memory, ALU and program_counter control signals
//   that the instruction_sequencer drives and observes.
//
//   master modport : the sequencer (drives requests, strobes and flags)
//   slave  modport : the environment (memory, ALU, program_counter)
//
//   pc            current program_counter value
//   mem_req       instruction read request
//   mem_addr      read address (pc while fetching, else 0)
//   mem_ready     read data valid, completes the request
//   mem_data      instruction word
//   alu_start     one-cycle ALU start pulse
//   alu_op        ALU opcode
//   alu_operand   ALU operand (IR[7:0])
//   alu_done      ALU completion
//   alu_zero      ALU zero result, valid with alu_done
//   enable        PC advance strobe
//   jump          unconditional jump request to the PC
//   jz            conditional jump request to the PC
//   zero_flag     registered zero flag
//   jump_address  jump target (IR[7:0])
//   halted        HALT executed
//   fault         fetch timeout
// -----------------------------------------------------------------------------
interface instruction_sequencer_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);

  logic [WORD_WIDTH-1:0]  pc;
  logic                   mem_req;
  logic [WORD_WIDTH-1:0]  mem_addr;
  logic                   mem_ready;
  logic [INSTR_WIDTH-1:0] mem_data;
  logic                   alu_start;
  logic [3:0]             alu_op;
  logic [WORD_WIDTH-1:0]  alu_operand;
  logic                   alu_done;
  logic                   alu_zero;
  logic                   enable;
  logic                   jump;
  logic                   jz;
  logic                   zero_flag;
  logic [WORD_WIDTH-1:0]  jump_address;
  logic                   halted;
  logic                   fault;

  modport master (
    input  pc, mem_ready, mem_data, alu_done, alu_zero,
    output mem_req, mem_addr, alu_start, alu_op, alu_operand,
           enable, jump, jz, zero_flag, jump_address, halted, fault
  );

  modport slave (
    output pc, mem_ready, mem_data, alu_done, alu_zero,
    input  mem_req, mem_addr, alu_start, alu_op, alu_operand,
           enable, jump, jz, zero_flag, jump_address, halted, fault
  );

endinterface

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//   Control-side driver of program_counter. Fetches the instruction at pc,
//   decodes it, runs ALU ops over a start/done handshake and issues one
//   enable/jump/jz strobe per instruction.
//
//   Opcodes (IR[15:12]): 0 NOP, 1 JMP, 2 JZ, 3..7 reserved (NOP),
//                        8..E ALU ops, F HALT. IR[7:0] is operand/target.
//
//   Ports:
//     clock   single clock, all state on posedge
//     reset   synchronous, active-high; every output reads 0 while high
//     bus     instruction_sequencer_if.master (memory, ALU and PC signals)
//
//   Optional feature: define SEQ_FETCH_TIMEOUT_EN to enable the fetch
//   timeout. FETCH then gives up after MEM_TIMEOUT cycles without mem_ready
//   and parks in FAULT (fault=1) until reset. Without it FETCH waits forever
//   and fault is tied 0.
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int WORD_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  instruction_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_ADVANCE,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                 state;
  state_t                 state_next;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   zero_q;
  logic                   timeout;

  logic [3:0]             opcode;
  logic [WORD_WIDTH-1:0]  operand;
  logic                   is_alu;

  assign opcode  = ir[INSTR_WIDTH-1 -: 4];
  assign operand = ir[WORD_WIDTH-1:0];
  // 8..E: top bit set, excluding HALT.
  assign is_alu  = opcode[3] && (opcode != OP_HALT);

  // The middle instruction bits carry no meaning.
  logic unused_bits;
  assign unused_bits = ^ir[INSTR_WIDTH-5:WORD_WIDTH];

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) < 4) ? 4 : $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] fetch_cnt;

  // Counts FETCH cycles already spent; every entry into FETCH comes from a
  // non-FETCH state or reset, so the count starts at 0 on each fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (state == S_FETCH) begin
      fetch_cnt <= fetch_cnt + 1'b1;
    end else begin
      fetch_cnt <= '0;
    end
  end

  // True in the last allowed FETCH cycle; mem_ready in that cycle still wins.
  assign timeout = (fetch_cnt == CNT_W'(MEM_TIMEOUT - 1));
`else
  assign timeout = 1'b0;

  logic unused_timeout;
  assign unused_timeout = (MEM_TIMEOUT == 0);
`endif

  // State, instruction register and zero flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_FETCH;
      ir     <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == S_FETCH) && bus.mem_ready) begin
        ir <= bus.mem_data;
      end
      if ((state == S_WAIT) && bus.alu_done) begin
        zero_q <= bus.alu_zero;
      end
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (is_alu) begin
          state_next = S_EXEC;
        end else if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_ADVANCE;
        end
      end
      S_EXEC:    state_next = S_WAIT;
      S_WAIT:    if (bus.alu_done) state_next = S_ADVANCE;
      S_ADVANCE: state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_FETCH;
    endcase
  end

  // Outputs decode from state. Reset is folded in combinationally so every
  // output is 0 for the whole reset window, including the first cycle before
  // the synchronous reset has taken effect.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_addr     = '0;
    bus.alu_start    = 1'b0;
    bus.alu_op       = '0;
    bus.alu_operand  = '0;
    bus.enable       = 1'b0;
    bus.jump         = 1'b0;
    bus.jz           = 1'b0;
    bus.jump_address = '0;
    bus.halted       = 1'b0;
    bus.fault        = 1'b0;
    bus.zero_flag    = zero_q && !reset;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = bus.pc;
        end
        S_EXEC: begin
          bus.alu_start   = 1'b1;
          bus.alu_op      = opcode;
          bus.alu_operand = operand;
        end
        S_WAIT: begin
          bus.alu_op      = opcode;
          bus.alu_operand = operand;
        end
        S_ADVANCE: begin
          bus.enable       = 1'b1;
          bus.jump         = (opcode == OP_JMP);
          bus.jz           = (opcode == OP_JZ);
          bus.jump_address = operand;
        end
        S_HALT: bus.halted = 1'b1;
`ifdef SEQ_FETCH_TIMEOUT_EN
        S_FAULT: bus.fault = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//   Directed scenarios for instruction_sequencer. Inputs change on the falling
//   edge, outputs are compared 1 time unit later. Strobe vector layout:
//   {mem_req, alu_start, enable, jump, jz, zero_flag, halted, fault}.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  instruction_sequencer_if #(.WORD_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  instruction_sequencer #(
    .WORD_WIDTH  (8),
    .INSTR_WIDTH (16),
    .MEM_TIMEOUT (15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] strobes();
    return {bus.mem_req, bus.alu_start, bus.enable, bus.jump,
            bus.jz, bus.zero_flag, bus.halted, bus.fault};
  endfunction

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [35:0] all_out;
    bus.pc = 8'h33; bus.mem_ready = 1'b1; bus.mem_data = 16'h1055;
    bus.alu_done = 1'b1; bus.alu_zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      all_out = {strobes(), bus.mem_addr, bus.alu_op, bus.alu_operand, bus.jump_address};
      checks++;
      if (all_out !== 36'h0) begin
        errors++; $display("FAIL reset_outputs cycle %0d got %h want 0", i, all_out);
      end
    end
    cyc();
    reset = 1'b0; bus.mem_ready = 1'b0; bus.alu_done = 1'b0; bus.alu_zero = 1'b0;
    #1;
    checks++;
    if (strobes() !== 8'h80) begin
      errors++; $display("FAIL release_strobes got %b want %b", strobes(), 8'h80);
    end
    checks++;
    if (bus.mem_addr !== 8'h33) begin
      errors++; $display("FAIL release_mem_addr got %h want 33", bus.mem_addr);
    end
  endtask

  task automatic test_jmp();
    bus.pc = 8'h05; bus.mem_data = 16'h102A; bus.mem_ready = 1'b1; #1;
    checks++;
    if (bus.mem_addr !== 8'h05) begin
      errors++; $display("FAIL jmp_fetch_addr got %h want 05", bus.mem_addr);
    end
    cyc(); bus.mem_ready = 1'b0; bus.pc = 8'h06; #1;
    checks++;
    if ({strobes(), bus.mem_addr} !== 16'h0000) begin
      errors++; $display("FAIL jmp_decode got %h want 0000", {strobes(), bus.mem_addr});
    end
    cyc(); #1;
    checks++;
    if ({strobes(), bus.jump_address} !== {8'h30, 8'h2A}) begin
      errors++; $display("FAIL jmp_advance got %h want 302a", {strobes(), bus.jump_address});
    end
    cyc(); #1;
    checks++;
    if ({strobes(), bus.jump_address, bus.mem_addr} !== {8'h80, 8'h00, 8'h06}) begin
      errors++; $display("FAIL jmp_refetch got %h want 800006",
                         {strobes(), bus.jump_address, bus.mem_addr});
    end
  endtask

  task automatic test_alu_jz();
    bus.mem_data = 16'h8003; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h00) begin
      errors++; $display("FAIL alu_decode got %b want 00000000", strobes());
    end
    cyc(); #1;
    checks++;
    if ({strobes(), bus.alu_op, bus.alu_operand} !== {8'h40, 4'h8, 8'h03}) begin
      errors++; $display("FAIL alu_exec got %h want 40803", {strobes(), bus.alu_op, bus.alu_operand});
    end
    cyc(); #1;
    checks++;
    if ({strobes(), bus.alu_op, bus.alu_operand} !== {8'h00, 4'h8, 8'h03}) begin
      errors++; $display("FAIL alu_wait_hold got %h want 00803", {strobes(), bus.alu_op, bus.alu_operand});
    end
    cyc();
    cyc(); bus.alu_done = 1'b1; bus.alu_zero = 1'b1; #1;
    checks++;
    if (strobes() !== 8'h00) begin
      errors++; $display("FAIL alu_wait_done got %b want 00000000", strobes());
    end
    cyc(); bus.alu_done = 1'b0; bus.alu_zero = 1'b0; #1;
    checks++;
    if ({strobes(), bus.alu_op} !== {8'h24, 4'h0}) begin
      errors++; $display("FAIL alu_advance got %h want 240", {strobes(), bus.alu_op});
    end
    cyc(); #1;
    checks++;
    if (strobes() !== 8'h84) begin
      errors++; $display("FAIL alu_refetch got %b want 10000100", strobes());
    end
    bus.mem_data = 16'h2010; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h04) begin
      errors++; $display("FAIL jz_decode got %b want 00000100", strobes());
    end
    cyc(); #1;
    checks++;
    if ({strobes(), bus.jump_address} !== {8'h2C, 8'h10}) begin
      errors++; $display("FAIL jz_advance got %h want 2c10", {strobes(), bus.jump_address});
    end
    cyc(); #1;
    checks++;
    if (strobes() !== 8'h84) begin
      errors++; $display("FAIL jz_refetch got %b want 10000100", strobes());
    end
  endtask

  // zero_flag is 1 on entry; alu_done during EXEC must not touch it.
  task automatic test_done_in_exec();
    bus.mem_data = 16'h9055; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0;
    cyc(); bus.alu_done = 1'b1; bus.alu_zero = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h44) begin
      errors++; $display("FAIL exec_strobes got %b want 01000100", strobes());
    end
    cyc(); bus.alu_done = 1'b0; #1;
    checks++;
    if ({strobes(), bus.alu_op, bus.alu_operand} !== {8'h04, 4'h9, 8'h55}) begin
      errors++; $display("FAIL exec_done_ignored got %h want 04955", {strobes(), bus.alu_op, bus.alu_operand});
    end
    cyc(); bus.alu_done = 1'b1; bus.alu_zero = 1'b0; #1;
    cyc(); bus.alu_done = 1'b0; #1;
    checks++;
    if ({strobes(), bus.jump_address} !== {8'h20, 8'h55}) begin
      errors++; $display("FAIL exec_advance got %h want 2055", {strobes(), bus.jump_address});
    end
    cyc(); #1;
  endtask

  // Reserved opcode acts as NOP; mem_ready outside FETCH must not reload IR.
  task automatic test_reserved_stray_ready();
    bus.mem_data = 16'h5077; bus.mem_ready = 1'b1;
    cyc(); bus.mem_data = 16'h1099; bus.mem_ready = 1'b1; #1;
    checks++;
    if (strobes() !== 8'h00) begin
      errors++; $display("FAIL nop_decode got %b want 00000000", strobes());
    end
    cyc(); bus.mem_ready = 1'b0; #1;
    checks++;
    if ({strobes(), bus.jump_address} !== {8'h20, 8'h77}) begin
      errors++; $display("FAIL nop_advance got %h want 2077", {strobes(), bus.jump_address});
    end
    cyc(); #1;
    checks++;
    if (strobes() !== 8'h80) begin
      errors++; $display("FAIL nop_refetch got %b want 10000000", strobes());
    end
  endtask

  task automatic test_halt();
    bus.mem_data = 16'hF000; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.mem_ready = 1'b1; #1;
      checks++;
      if ({strobes(), bus.mem_addr} !== {8'h02, 8'h00}) begin
        errors++; $display("FAIL halt_hold cycle %0d got %h want 0200", i, {strobes(), bus.mem_addr});
      end
    end
    cyc(); reset = 1'b1; bus.mem_ready = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h00) begin
      errors++; $display("FAIL halt_reset got %b want 00000000", strobes());
    end
    cyc(); reset = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h80) begin
      errors++; $display("FAIL halt_resume got %b want 10000000", strobes());
    end
  endtask

  task automatic test_reset_in_wait();
    bus.mem_data = 16'hA001; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0;
    cyc();
    cyc(); bus.alu_done = 1'b1; bus.alu_zero = 1'b1;
    cyc(); bus.alu_done = 1'b0; bus.alu_zero = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h24) begin
      errors++; $display("FAIL rstwait_setup got %b want 00100100", strobes());
    end
    cyc();
    bus.mem_data = 16'hB002; bus.mem_ready = 1'b1;
    cyc(); bus.mem_ready = 1'b0;
    cyc();
    cyc(); #1;
    checks++;
    if ({strobes(), bus.alu_op} !== {8'h04, 4'hB}) begin
      errors++; $display("FAIL rstwait_in_wait got %h want 04b", {strobes(), bus.alu_op});
    end
    cyc(); reset = 1'b1; bus.alu_done = 1'b1; bus.alu_zero = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h00) begin
      errors++; $display("FAIL rstwait_during got %b want 00000000", strobes());
    end
    cyc(); reset = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h80) begin
      errors++; $display("FAIL rstwait_after got %b want 10000000", strobes());
    end
    cyc(); bus.alu_done = 1'b0; #1;
    checks++;
    if (strobes() !== 8'h80) begin
      errors++; $display("FAIL rstwait_no_enable got %b want 10000000", strobes());
    end
  endtask

  task automatic test_fetch_timeout();
    logic [7:0] want;
    cyc(); reset = 1'b1; bus.mem_ready = 1'b0; bus.pc = 8'h40;
    cyc(); reset = 1'b0; #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        cyc(); #1;
      end
      want = (TO_EN && i >= 15) ? 8'h01 : 8'h80;
      checks++;
      if (strobes() !== want) begin
        errors++; $display("FAIL fetch_timeout cycle %0d got %b want %b", i, strobes(), want);
      end
    end
  endtask

  initial begin
    bus.pc = '0; bus.mem_ready = 1'b0; bus.mem_data = '0;
    bus.alu_done = 1'b0; bus.alu_zero = 1'b0;
    test_reset();
    test_jmp();
    test_alu_jz();
    test_done_in_exec();
    test_reserved_stray_ready();
    test_halt();
    test_reset_in_wait();
    test_fetch_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

endmodule
